multipath_delay_monitor: RTL and testbench

Parametrised path-delay measurement block for Trojan detection. It launches a transition simultaneously into CHANNELS keep-preserved gate chains and times each arrival in clock cycles. It averages the timing over 2^LOG_RUNS runs of alternating polarity and flags every channel whose averaged delay falls outside its golden window or times out. It sits between the test controller, which issues the start pulse and golden windows, and the result readout logic.

---
 rtl/delay_mon_pkg.sv | 22 ++
 rtl/delay_path.sv | 36 +++
 rtl/multipath_delay_monitor.sv | 185 ++++++++++++++++++
 tb/tb_multipath_delay_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/delay_mon_pkg.sv
// Shared types and constants for the multipath delay monitor.
`timescale 1ns/1ps
package delay_mon_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_ACCUM  = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  // Depth of the synchroniser on every path output.
  localparam int SYNC_STAGES = 2;

  // Accumulator width: the sum of 2^log_runs values of cnt_w bits never overflows.
  function automatic int sum_width(input int cnt_w, input int log_runs);
    return cnt_w + log_runs;
  endfunction

endpackage

// File: rtl/delay_path.sv
// Non-inverting chain of alternating NOT / NAND gates under test.
// Every node is kept so synthesis cannot collapse the chain; the gate
// delays only model propagation time in simulation.
`timescale 1ns/1ps
module delay_path #(
  parameter int STAGES    = 32,
  parameter int STAGE_DLY = 1
) (
  input  logic IN,
  input  logic VCC,
  input  logic GND,
  output logic OUT
);

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    (* keep = 1 *) logic a;
    (* keep = 1 *) logic y;

    if (i == 0) begin : g_first
      assign a = IN;
    end else begin : g_link
      assign a = g_stage[i-1].y;
    end

    if (i % 2 == 0) begin : g_not
      // Inverter, written with a GND tie so the tie-off stays in the netlist.
      assign #(STAGE_DLY) y = ~(a | GND);
    end else begin : g_nand
      // NAND with the second input tied high.
      assign #(STAGE_DLY) y = ~(a & VCC);
    end
  end

  assign OUT = g_stage[STAGES-1].y;

endmodule

// File: rtl/multipath_delay_monitor.sv
// Launches a transition into CHANNELS delay chains, times each arrival in
// clock cycles, averages over 2^LOG_RUNS runs of alternating polarity and
// flags channels outside their golden window or that never arrived.
`timescale 1ns/1ps
module multipath_delay_monitor
  import delay_mon_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int STAGES    = 32,
  parameter int CNT_W     = 12,
  parameter int TMAX      = 4000,
  parameter int LOG_RUNS  = 2,
  parameter int STAGE_DLY = 1,
  // Channels whose chain models an inserted (slower) path in simulation.
  parameter logic [CHANNELS-1:0] SLOW_CH_MASK = '0,
  parameter int SLOW_STAGE_DLY = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      VCC,
  input  logic                      GND,
  input  logic                      START,
  input  logic [CHANNELS*CNT_W-1:0] GOLDEN_LO,
  input  logic [CHANNELS*CNT_W-1:0] GOLDEN_HI,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [CHANNELS*CNT_W-1:0] RESULT,
  output logic [CHANNELS-1:0]       TIMEOUT,
  output logic [CHANNELS-1:0]       FLAG
);

  localparam int SUM_W = sum_width(CNT_W, LOG_RUNS);
  localparam int RUNS  = 1 << LOG_RUNS;
  localparam int RW    = LOG_RUNS + 1;
  localparam logic [RW-1:0]    RUN_LAST = RW'(RUNS - 1);
  localparam logic [CNT_W-1:0] TMAX_C   = CNT_W'(TMAX);

  state_t                state;
  logic                  lvl;
  logic [CNT_W-1:0]      cnt;
  logic [CHANNELS-1:0]   got;
  logic [RW-1:0]         run_idx;
  logic [CNT_W-1:0]      cap [CHANNELS];
  logic [SUM_W-1:0]      sum [CHANNELS];

  logic [CHANNELS-1:0]   path_out;
  logic [CHANNELS-1:0]   sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0]   sync2;
  logic [CHANNELS-1:0]   at_lvl;

  // Truncated average; a timed-out channel saturates to all ones.
  function automatic logic [CNT_W-1:0] avg_sat(input logic [SUM_W-1:0] s,
                                               input logic tmo);
    if (tmo) return '1;
    return CNT_W'(s >> LOG_RUNS);
  endfunction

  // Inclusive window test; an inverted window (lo > hi) always fails.
  function automatic logic out_of_window(input logic [CNT_W-1:0] r,
                                         input logic [CNT_W-1:0] lo,
                                         input logic [CNT_W-1:0] hi,
                                         input logic tmo);
    return tmo || (r < lo) || (r > hi);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam int DLY = SLOW_CH_MASK[c] ? SLOW_STAGE_DLY : STAGE_DLY;
    logic tap;

    delay_path #(
      .STAGES    (STAGES),
      .STAGE_DLY (DLY)
    ) u_path (
      .IN  (lvl),
      .VCC (VCC),
      .GND (GND),
      .OUT (tap)
    );

    assign path_out[c] = tap;
  end

  assign sync2  = sync_q[SYNC_STAGES-1];
  assign at_lvl = lvl ? sync2 : ~sync2;

  // Bring the asynchronous path outputs into the clock domain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= path_out;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Measurement sequencer: settle, launch, time arrivals, accumulate, report.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      lvl     <= 1'b0;
      cnt     <= '0;
      got     <= '0;
      run_idx <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RESULT  <= '0;
      TIMEOUT <= '0;
      FLAG    <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cap[c] <= '0;
        sum[c] <= '0;
      end
    end else begin
      DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          // DONE still high means this is the report cycle: drop START.
          if (START && !DONE) begin
            for (int c = 0; c < CHANNELS; c++) sum[c] <= '0;
            TIMEOUT <= '0;
            run_idx <= '0;
            cnt     <= '0;
            BUSY    <= 1'b1;
            state   <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if ((&at_lvl) || (cnt == TMAX_C)) begin
            state <= S_LAUNCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_LAUNCH: begin
          lvl   <= ~lvl;
          cnt   <= '0;
          got   <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          cnt <= cnt + 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            if (!got[c]) begin
              if (at_lvl[c]) begin
                cap[c] <= cnt;
                got[c] <= 1'b1;
              end else if (cnt == TMAX_C) begin
                cap[c]     <= TMAX_C;
                got[c]     <= 1'b1;
                TIMEOUT[c] <= 1'b1;
              end
            end
          end
          if ((&(got | at_lvl)) || (cnt == TMAX_C)) state <= S_ACCUM;
        end

        S_ACCUM: begin
          for (int c = 0; c < CHANNELS; c++) sum[c] <= sum[c] + SUM_W'(cap[c]);
          run_idx <= run_idx + 1'b1;
          cnt     <= '0;
          state   <= (run_idx == RUN_LAST) ? S_REPORT : S_SETTLE;
        end

        S_REPORT: begin
          for (int c = 0; c < CHANNELS; c++) begin
            RESULT[c*CNT_W +: CNT_W] <= avg_sat(sum[c], TIMEOUT[c]);
            FLAG[c] <= out_of_window(avg_sat(sum[c], TIMEOUT[c]),
                                     GOLDEN_LO[c*CNT_W +: CNT_W],
                                     GOLDEN_HI[c*CNT_W +: CNT_W],
                                     TIMEOUT[c]);
          end
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multipath_delay_monitor.sv
// Bench for multipath_delay_monitor: three instances (nominal, one slowed
// channel, one stuck channel with short timeout) against an arrival-time model.
`timescale 1ns/1ps
module tb_multipath_delay_monitor;

  localparam int CH   = 4;
  localparam int CW   = 12;
  localparam int ST   = 32;
  localparam int TCLK = 10;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n = 1'b0;
  logic            vcc   = 1'b1;
  logic            gnd   = 1'b0;
  logic [NDUT-1:0] start = '0;
  logic [CH*CW-1:0] lo = '0;
  logic [CH*CW-1:0] hi = '0;
  logic [NDUT-1:0] busy;
  logic [NDUT-1:0] done;
  logic [CH*CW-1:0] result [NDUT];
  logic [CH-1:0]    tmo    [NDUT];
  logic [CH-1:0]    flag   [NDUT];

  int checks   = 0;
  int failures = 0;

  multipath_delay_monitor #(
    .CHANNELS(CH), .STAGES(ST), .CNT_W(CW), .TMAX(4000), .LOG_RUNS(2), .STAGE_DLY(1)
  ) dut_nom (
    .CLK(clk), .RST_N(rst_n), .VCC(vcc), .GND(gnd), .START(start[0]),
    .GOLDEN_LO(lo), .GOLDEN_HI(hi), .BUSY(busy[0]), .DONE(done[0]),
    .RESULT(result[0]), .TIMEOUT(tmo[0]), .FLAG(flag[0])
  );

  multipath_delay_monitor #(
    .CHANNELS(CH), .STAGES(ST), .CNT_W(CW), .TMAX(4000), .LOG_RUNS(2), .STAGE_DLY(1),
    .SLOW_CH_MASK(4'b0100), .SLOW_STAGE_DLY(2)
  ) dut_slow (
    .CLK(clk), .RST_N(rst_n), .VCC(vcc), .GND(gnd), .START(start[1]),
    .GOLDEN_LO(lo), .GOLDEN_HI(hi), .BUSY(busy[1]), .DONE(done[1]),
    .RESULT(result[1]), .TIMEOUT(tmo[1]), .FLAG(flag[1])
  );

  multipath_delay_monitor #(
    .CHANNELS(CH), .STAGES(ST), .CNT_W(CW), .TMAX(50), .LOG_RUNS(2), .STAGE_DLY(1)
  ) dut_to (
    .CLK(clk), .RST_N(rst_n), .VCC(vcc), .GND(gnd), .START(start[2]),
    .GOLDEN_LO(lo), .GOLDEN_HI(hi), .BUSY(busy[2]), .DONE(done[2]),
    .RESULT(result[2]), .TIMEOUT(tmo[2]), .FLAG(flag[2])
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arrival model: a path of d ns is seen 2 synchroniser cycles after the
  // first clock edge following its arrival; a stuck path never arrives.
  function automatic int exp_res(input int k, input int c);
    int d;
    if (k == 2 && c == 1) return 'hFFF;
    d = ST * ((k == 1 && c == 2) ? 2 : 1);
    return 2 + d / TCLK;
  endfunction

  function automatic logic [CH-1:0] exp_tmo(input int k);
    return (k == 2) ? 4'b0010 : 4'b0000;
  endfunction

  task automatic set_window(input int c, input int l, input int h);
    lo[c*CW +: CW] = CW'(l);
    hi[c*CW +: CW] = CW'(h);
  endtask

  task automatic set_all(input int l, input int h);
    for (int c = 0; c < CH; c++) set_window(c, l, h);
  endtask

  task automatic check_idle_zero(input int k, input string tag);
    check_val({tag, ".busy"},    busy[k],   0);
    check_val({tag, ".done"},    done[k],   0);
    check_val({tag, ".result"},  result[k], 0);
    check_val({tag, ".timeout"}, tmo[k],    0);
    check_val({tag, ".flag"},    flag[k],   0);
  endtask

  // One START on instance k; optionally extra START pulses while busy and in
  // the DONE cycle, which must not trigger further measurements.
  task automatic measure(input int k, input bit stray, input string tag);
    int cyc;
    int ndone;
    int r;
    int l;
    int h;
    logic [CH-1:0] ef;
    logic [CH-1:0] et;
    @(negedge clk); start[k] = 1'b1;
    @(negedge clk); start[k] = 1'b0;
    cyc = 1;
    while (done[k] !== 1'b1 && cyc < 3000) begin
      if (cyc == 3) check_val({tag, ".busy_run"}, busy[k], 1);
      start[k] = (stray && cyc == 12);
      @(negedge clk);
      cyc++;
    end
    start[k] = 1'b0;
    if (done[k] !== 1'b1) begin
      check_val({tag, ".done_arrived"}, 0, 1);
      return;
    end
    ndone = 1;
    if (k == 2) check_val({tag, ".latency_ok"}, (cyc >= 190 && cyc <= 270), 1);
    et = exp_tmo(k);
    for (int c = 0; c < CH; c++) begin
      r = exp_res(k, c);
      l = int'(lo[c*CW +: CW]);
      h = int'(hi[c*CW +: CW]);
      ef[c] = et[c] || (r < l) || (r > h);
      check_val($sformatf("%s.result%0d", tag, c), result[k][c*CW +: CW], r);
    end
    check_val({tag, ".flag"},    flag[k], ef);
    check_val({tag, ".timeout"}, tmo[k],  et);
    if (stray) start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done[k] === 1'b1) ndone++;
      @(negedge clk);
    end
    check_val({tag, ".done_count"}, ndone, 1);
    check_val({tag, ".busy_after"}, busy[k], 0);
  endtask

  initial begin
    int k;
    int n;
    force dut_to.g_ch[1].tap = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== '0 || done !== '0) n++;
    end
    check_val("idle.busy_done_low", n, 0);
    for (int d = 0; d < NDUT; d++) check_idle_zero(d, $sformatf("reset%0d", d));

    // Nominal, inserted delay and timeout with the reference window
    set_all(4, 6);
    measure(0, 1'b1, "nominal");
    measure(1, 1'b0, "inserted");
    measure(2, 1'b0, "timeout");

    // Window edges: exact hit, just below, just above, inverted, full range
    set_all(5, 5);     measure(0, 1'b0, "win_5_5");
    set_all(6, 8);     measure(0, 1'b0, "win_6_8");
    set_all(4, 4);     measure(0, 1'b0, "win_4_4");
    set_all(6, 4);     measure(0, 1'b0, "win_inv");
    set_all(0, 'hFFF); measure(2, 1'b0, "win_full_to");

    // Randomized windows, instances, gaps and stray START pulses
    for (int it = 0; it < 8; it++) begin
      k = (it == 7) ? 2 : int'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++)
        set_window(c, int'($urandom_range(0, 9)), int'($urandom_range(0, 10)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      measure(k, 1'($urandom_range(0, 1)), $sformatf("rand%0d", it));
    end

    // Reset in the middle of the second run
    set_all(4, 6);
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat ($urandom_range(12, 17)) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero(0, "midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    measure(0, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
